// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x32 register file: arbitrates the single
// write port between pipeline WB and long-latency results, and stalls ID on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int LU_DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rd_we_i,
  input  logic        id_long_i,
  output logic        id_stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  output logic        pipe_freeze_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o
);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [2:0] LDEP = 3'(LU_DEPTH);

  logic [31:0] pending_q, pending_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  starve_q, starve_d;
  logic [2:0]  outst_q, outst_d;

  logic       wb_req, lu_acc, lu_direct, lu_to_hold, hold_gnt;
  logic       retire, fire, issue_long;
  logic [4:0] retire_rd;
  logic       haz_rs1, haz_rs2, haz_waw, haz_full;

  // Port arbitration: freeze drains hold, else WB, else hold, else a direct long result.
  always_comb begin
    pipe_freeze_o = hold_valid_q & (starve_q == SLIM);
    lu_ready_o    = ~hold_valid_q;
    wb_req        = wb_valid_i & (wb_rd_i != 5'd0) & ~pipe_freeze_o;
    lu_acc        = lu_valid_i & ~hold_valid_q;
    hold_gnt      = hold_valid_q & (pipe_freeze_o | ~wb_req);
    lu_direct     = lu_acc & (lu_rd_i != 5'd0) & ~wb_req;
    lu_to_hold    = lu_acc & (lu_rd_i != 5'd0) & wb_req;
    rf_we_o       = 1'b0;
    rf_rd_o       = 5'd0;
    rf_data_o     = 32'd0;
    if (hold_gnt) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = hold_rd_q;
      rf_data_o = hold_data_q;
    end else if (wb_req) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = wb_rd_i;
      rf_data_o = wb_data_i;
    end else if (lu_direct) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = lu_rd_i;
      rf_data_o = lu_data_i;
    end
  end

  // hold and a fresh accept are mutually exclusive, so at most one retire per cycle.
  assign retire    = hold_gnt | (lu_acc & ~lu_to_hold);
  assign retire_rd = hold_gnt ? hold_rd_q : lu_rd_i;

  // A same-cycle write of a source register is forwarded by the file, so no RAW stall.
  assign haz_rs1  = (id_rs1_i != 5'd0) & pending_q[id_rs1_i] & ~(rf_we_o & (rf_rd_o == id_rs1_i));
  assign haz_rs2  = (id_rs2_i != 5'd0) & pending_q[id_rs2_i] & ~(rf_we_o & (rf_rd_o == id_rs2_i));
  assign haz_waw  = id_rd_we_i & (id_rd_i != 5'd0) & pending_q[id_rd_i];
  assign haz_full = id_long_i & (outst_q == LDEP);

  assign id_stall_o = id_valid_i & (pipe_freeze_o | haz_rs1 | haz_rs2 | haz_waw | haz_full);
  assign fire       = id_valid_i & ~id_stall_o;
  assign issue_long = fire & id_long_i;

  always_comb begin
    pending_d = pending_q;
    if (retire) pending_d[retire_rd] = 1'b0;
    if (issue_long & id_rd_we_i & (id_rd_i != 5'd0)) pending_d[id_rd_i] = 1'b1;
    pending_d[0] = 1'b0;

    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    if (hold_gnt) hold_valid_d = 1'b0;
    if (lu_to_hold) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = lu_rd_i;
      hold_data_d  = lu_data_i;
    end

    if (~hold_valid_q | hold_gnt) starve_d = 4'd0;
    else if (starve_q != SLIM)    starve_d = starve_q + 4'd1;
    else                          starve_d = starve_q;

    outst_d = outst_q + {2'b00, issue_long} - {2'b00, retire};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      starve_q     <= '0;
      outst_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      starve_q     <= starve_d;
      outst_q      <= outst_d;
    end
  end
endmodule
